sccb_target: RTL and testbench

SCCB_TARGET -- requirements
Module: sccb_target

---
 rtl/sccb_target.sv | 225 ++++++++++++++++++++++
 tb/tb_sccb_target.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB (I2C-style) register-bus target with open-drain data pin
//
// Purpose: Decodes SCCB write and read transactions addressed to DEV_ADDR.
//   Writes are issued as single-clk wr_en pulses with reg_addr and wr_data.
//   Reads return rd_data for the current reg_addr.
//   Optional macro SCCB_TARGET_AUTOINC_EN makes reg_addr advance after each
//   written byte and after each master-ACKed read byte.
//
// Ports:
//   clk       in   system clock, at least 16x the scl frequency
//   reset     in   asynchronous active-high reset
//   scl       in   bus clock (asynchronous)
//   sda_in    in   bus data as seen on the pad (asynchronous)
//   sda_oe    out  1 = pull sda low, 0 = release sda
//   wr_en     out  one-clk register write strobe
//   reg_addr  out  current register pointer
//   wr_data   out  write data, valid with wr_en
//   rd_data   in   register contents at reg_addr (combinational)
//   busy      out  high from an addressed START until STOP or master NACK

module sccb_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEV_ADDR  = 3'd1,
    ST_ACK       = 3'd2,
    ST_REG_ADDR  = 3'd3,
    ST_WR_DATA   = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // Input synchronizers; reset to 1 so an idle bus is assumed after reset.
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync[0] <= scl;
      sda_sync[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_d <= scl_sync[SYNC_STAGES-1];
      sda_d <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // START/STOP only need scl high now, so a START whose sda fall lands on
  // the same clk as the scl rise is still recognised (and wins over the sample).
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  state_t     state;
  state_t     ack_next;   // where the FSM goes when the ACK slot ends
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       wr_pend;    // byte captured; wr_en follows on the next clk
  logic       rd_load;    // reload shreg from rd_data on the next scl fall
  logic       rd_done;    // all 8 read bits clocked out
  logic [7:0] rx_byte;

  assign rx_byte = {shreg[6:0], sda_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ack_next <= ST_IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      wr_pend  <= 1'b0;
      rd_load  <= 1'b0;
      rd_done  <= 1'b0;
      sda_oe   <= 1'b0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      reg_addr <= 8'h00;
      wr_data  <= 8'h00;
    end else begin
      wr_en   <= wr_pend;
      wr_pend <= 1'b0;
`ifdef SCCB_TARGET_AUTOINC_EN
      if (wr_en) reg_addr <= reg_addr + 8'd1;
`endif
      if (stop_det) begin
        state   <= ST_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 3'd0;
        rd_load <= 1'b0;
        rd_done <= 1'b0;
      end else if (start_det) begin
        state   <= ST_DEV_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= 3'd0;
        rd_load <= 1'b0;
        rd_done <= 1'b0;
      end else begin
        case (state)
          ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == ST_DEV_ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state    <= ST_ACK;
                    busy     <= 1'b1;
                    ack_next <= rx_byte[0] ? ST_RD_DATA : ST_REG_ADDR;
                  end else begin
                    state <= ST_WAIT_STOP;
                    busy  <= 1'b0;
                  end
                end else if (state == ST_REG_ADDR) begin
                  reg_addr <= rx_byte;
                  state    <= ST_ACK;
                  ack_next <= ST_WR_DATA;
                end else begin
                  wr_data  <= rx_byte;
                  wr_pend  <= 1'b1;
                  state    <= ST_ACK;
                  ack_next <= ST_WR_DATA;
                end
              end
            end
          end

          // First scl fall starts pulling sda low, the second ends the slot.
          ST_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                state   <= ack_next;
                bit_cnt <= 3'd0;
                if (ack_next == ST_RD_DATA) begin
                  shreg   <= rd_data;
                  sda_oe  <= ~rd_data[7];
                  rd_done <= 1'b0;
                end else begin
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          // Master samples on the rise; the next bit is presented on the fall.
          ST_RD_DATA: begin
            if (scl_rise && !rd_load) begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) rd_done <= 1'b1;
            end
            if (scl_fall) begin
              if (rd_load) begin
                shreg   <= rd_data;
                sda_oe  <= ~rd_data[7];
                rd_load <= 1'b0;
              end else if (rd_done) begin
                sda_oe  <= 1'b0;
                rd_done <= 1'b0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe <= ~shreg[7];
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                state   <= ST_RD_DATA;
                rd_load <= 1'b1;
                bit_cnt <= 3'd0;
`ifdef SCCB_TARGET_AUTOINC_EN
                reg_addr <= reg_addr + 8'd1;
`endif
              end else begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end

          default: ;  // IDLE and WAIT_STOP ignore bus activity
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - directed self-checking bench for sccb_target

module tb_sccb_target;

`ifdef SCCB_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_DEV  = 32'd1;
  localparam logic [31:0] ST_WAIT = 32'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       wr_en;
  logic       busy;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       sda_bus;
  logic [7:0] mem [256];

  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = mem[reg_addr];

  always #5 clk = ~clk;

  sccb_target dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .wr_en    (wr_en),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  int         errors = 0;
  int         checks = 0;
  int         oe_cnt = 0;
  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic       smp;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_a.push_back(reg_addr);
      wr_d.push_back(wr_data);
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit slot: scl low, data change mid-low, scl high, sample mid-high.
  task automatic bit_slot(input logic b);
    scl = 1'b0; tick(6);
    sda_m = b;  tick(6);
    scl = 1'b1; tick(5);
    smp = sda_bus; tick(5);
  endtask

  task automatic bus_start();
    scl = 1'b0;   tick(6);
    sda_m = 1'b1; tick(6);
    scl = 1'b1;   tick(10);
    sda_m = 1'b0; tick(10);
  endtask

  task automatic bus_stop();
    scl = 1'b0;   tick(6);
    sda_m = 1'b0; tick(6);
    scl = 1'b1;   tick(10);
    sda_m = 1'b1; tick(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) bit_slot(b[i]);
    bit_slot(1'b1);
    acked = ~smp;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1);
      v[i] = smp;
    end
    bit_slot(nack);
  endtask

  logic       a0, a1, a2, a3;
  logic [7:0] v0, v1;
  logic [7:0] pat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h0A] = 8'h76;
    mem[8'h0B] = 8'h5C;

    // Reset state
    tick(5);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_state", 32'(dut.state), ST_IDLE);
    check("rst_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    reset = 1'b0;
    tick(10);

    // Simple write of 0x80 to register 0x12
    bus_start();
    send_byte(8'h42, a0);
    check("w1_busy", 32'(busy), 32'd1);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    bus_stop();
    tick(4);
    check("w1_ack0", 32'(a0), 32'd1);
    check("w1_ack1", 32'(a1), 32'd1);
    check("w1_ack2", 32'(a2), 32'd1);
    check("w1_wr_cnt", 32'(wr_a.size()), 32'd1);
    check("w1_addr", 32'(wr_a[0]), 32'h12);
    check("w1_data", 32'(wr_d[0]), 32'h80);
    check("w1_busy_end", 32'(busy), 32'd0);
    check("w1_state_end", 32'(dut.state), ST_IDLE);

    // Wrong device address
    wr_a.delete(); wr_d.delete(); oe_cnt = 0;
    bus_start();
    send_byte(8'h44, a0);
    check("na_state", 32'(dut.state), ST_WAIT);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    check("na_oe_cnt", 32'(oe_cnt), 32'd0);
    check("na_wr_cnt", 32'(wr_a.size()), 32'd0);
    check("na_state2", 32'(dut.state), ST_WAIT);
    check("na_busy", 32'(busy), 32'd0);
    bus_stop();
    tick(4);
    check("na_state_stop", 32'(dut.state), ST_IDLE);

    // Burst write across the 0xFF boundary
    wr_a.delete(); wr_d.delete();
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'hFF, a1);
    send_byte(8'hAA, a2);
    send_byte(8'hBB, a3);
    bus_stop();
    tick(4);
    check("bw_ack", 32'({a0, a1, a2, a3}), 32'hF);
    check("bw_wr_cnt", 32'(wr_a.size()), 32'd2);
    check("bw_addr0", 32'(wr_a[0]), 32'hFF);
    check("bw_data0", 32'(wr_d[0]), 32'hAA);
    check("bw_addr1", 32'(wr_a[1]), AUTOINC ? 32'h00 : 32'hFF);
    check("bw_data1", 32'(wr_d[1]), 32'hBB);

    // Register read with repeated START, master NACK
    wr_a.delete(); wr_d.delete();
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_start();
    send_byte(8'h43, a2);
    recv_byte(1'b1, v0);
    check("rd_ack", 32'({a0, a1, a2}), 32'h7);
    check("rd_data", 32'(v0), 32'h76);
    check("rd_state", 32'(dut.state), ST_WAIT);
    check("rd_busy", 32'(busy), 32'd0);
    check("rd_oe", 32'(sda_oe), 32'd0);
    bus_stop();
    tick(4);
    check("rd_wr_cnt", 32'(wr_a.size()), 32'd0);

    // Two-byte read, master ACKs the first byte
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_start();
    send_byte(8'h43, a2);
    recv_byte(1'b0, v0);
    recv_byte(1'b1, v1);
    bus_stop();
    tick(4);
    check("rd2_byte0", 32'(v0), 32'h76);
    check("rd2_byte1", 32'(v1), AUTOINC ? 32'h5C : 32'h76);

    // Reset during bit 5 of a data byte
    wr_a.delete(); wr_d.delete();
    pat = 8'h5A;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h12, a1);
    for (int i = 7; i >= 4; i--) bit_slot(pat[i]);
    scl = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    oe_cnt = 0;
    sda_m = pat[3]; tick(6);
    scl = 1'b1;     tick(10);
    for (int i = 2; i >= 0; i--) bit_slot(pat[i]);
    bit_slot(1'b1);
    tick(4);
    check("rs_wr_cnt", 32'(wr_a.size()), 32'd0);
    check("rs_oe_cnt", 32'(oe_cnt), 32'd0);
    check("rs_state", 32'(dut.state), ST_IDLE);
    check("rs_reg_addr", 32'(reg_addr), 32'd0);
    bus_stop();
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h33, a1);
    send_byte(8'h5A, a2);
    bus_stop();
    tick(4);
    check("rs2_ack", 32'({a0, a1, a2}), 32'h7);
    check("rs2_wr_cnt", 32'(wr_a.size()), 32'd1);
    check("rs2_addr", 32'(wr_a[0]), 32'h33);
    check("rs2_data", 32'(wr_d[0]), 32'h5A);

    // START landing on the 8th data bit sample
    wr_a.delete(); wr_d.delete();
    pat = 8'h80;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h12, a1);
    for (int i = 7; i >= 1; i--) bit_slot(pat[i]);
    scl = 1'b0;   tick(6);
    sda_m = 1'b1; tick(6);
    scl = 1'b1;
    sda_m = 1'b0;
    tick(8);
    check("cs_state", 32'(dut.state), ST_DEV);
    check("cs_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    check("cs_wr_cnt", 32'(wr_a.size()), 32'd0);
    tick(4);
    send_byte(8'h42, a2);
    check("cs_readdr_ack", 32'(a2), 32'd1);
    bus_stop();
    tick(4);
    check("cs_wr_cnt_end", 32'(wr_a.size()), 32'd0);
    check("cs_busy_end", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
